// File: rtl/clkdiv_ctrl.sv
// Sequencing controller for the integer clock divider: shadows ratio
// updates, stops the divider on a falling edge, reloads and settles.
module clkdiv_ctrl #(
  parameter int RATIO_WIDTH = 8,
  parameter int RESET_RATIO = 2,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_cfg_valid,
  input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
  output logic                   o_cfg_ready,
  input  logic                   i_div_clk,
  output logic                   o_div_en,
  output logic [RATIO_WIDTH-1:0] o_div_ratio,
  output logic                   o_bypass,
  output logic                   o_busy,
  output logic                   o_timeout,
  input  logic                   i_timeout_clr
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [RATIO_WIDTH-1:0] RST_RATIO =
    RATIO_WIDTH'(RESET_RATIO);
  localparam logic RST_BYP = (RESET_RATIO < 2);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] S_MAX = SW'(SETTLE_CYC - 1);
  localparam logic [RATIO_WIDTH-1:0] TWO = RATIO_WIDTH'(2);

  typedef enum logic [2:0] {
    OFF,
    RUN,
    DRAIN,
    LOAD,
    SETTLE
  } state_t;

  state_t state, state_d;

  logic [RATIO_WIDTH-1:0] shadow, shadow_d;
  logic [RATIO_WIDTH-1:0] ratio_d;
  logic [TW-1:0]          dcnt, dcnt_d;
  logic [SW-1:0]          scnt, scnt_d;

  logic div_en_d;
  logic bypass_d;
  logic busy_d;
  logic timeout_d;
  logic pending, pending_d;
  logic prev;
  logic fall;
  logic xfer;
  logic drain_exit;
  logic drain_max;

  assign fall        = prev & ~i_div_clk;
  assign o_cfg_ready = ~i_rst & ((state == OFF) | (state == RUN));
  assign xfer        = i_cfg_valid & o_cfg_ready;
  assign drain_max   = (dcnt == T_MAX);
  assign drain_exit  = fall | o_bypass | drain_max;

  always_comb begin
    state_d   = state;
    shadow_d  = shadow;
    ratio_d   = o_div_ratio;
    bypass_d  = o_bypass;
    div_en_d  = o_div_en;
    pending_d = pending;
    dcnt_d    = '0;
    scnt_d    = '0;
    timeout_d = o_timeout & ~i_timeout_clr;

    if (xfer) begin
      shadow_d = i_cfg_ratio;
    end

    unique case (state)
      OFF: begin
        div_en_d = 1'b0;
        if (xfer) begin
          state_d = LOAD;
        end else if (i_enable) begin
          state_d = SETTLE;
        end
      end
      RUN: begin
        div_en_d = ~o_bypass;
        if (xfer) begin
          state_d   = DRAIN;
          pending_d = 1'b1;
        end else if (!i_enable) begin
          state_d   = DRAIN;
          pending_d = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_exit) begin
          state_d   = pending ? LOAD : OFF;
          div_en_d  = 1'b0;
          pending_d = 1'b0;
          if (drain_max) begin
            timeout_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt + TW'(1);
        end
      end
      LOAD: begin
        div_en_d = 1'b0;
        ratio_d  = shadow;
        bypass_d = (shadow < TWO);
        state_d  = SETTLE;
      end
      SETTLE: begin
        div_en_d = 1'b0;
        if (scnt == S_MAX) begin
          if (i_enable) begin
            state_d  = RUN;
            div_en_d = ~o_bypass;
          end else begin
            state_d = OFF;
          end
        end else begin
          scnt_d = scnt + SW'(1);
        end
      end
      default: begin
        state_d  = OFF;
        div_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d == DRAIN) |
             (state_d == LOAD) |
             (state_d == SETTLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= OFF;
      shadow      <= RST_RATIO;
      o_div_ratio <= RST_RATIO;
      o_bypass    <= RST_BYP;
      o_div_en    <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      pending     <= 1'b0;
      prev        <= 1'b0;
      dcnt        <= '0;
      scnt        <= '0;
    end else begin
      state       <= state_d;
      shadow      <= shadow_d;
      o_div_ratio <= ratio_d;
      o_bypass    <= bypass_d;
      o_div_en    <= div_en_d;
      o_busy      <= busy_d;
      o_timeout   <= timeout_d;
      pending     <= pending_d;
      prev        <= i_div_clk;
      dcnt        <= dcnt_d;
      scnt        <= scnt_d;
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: vector table for the main
// reload flows plus hand sequences for timeout, overlap and reset.
module tb_clkdiv_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       vld;
  logic [7:0] rat;
  logic       rdy;
  logic       dclk;
  logic       div_en;
  logic [7:0] div_ratio;
  logic       byp;
  logic       busy;
  logic       tout;
  logic       tclr;

  int tests = 0;
  int fails = 0;

  clkdiv_ctrl #(
    .RATIO_WIDTH(8),
    .RESET_RATIO(2),
    .SETTLE_CYC(2),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_enable(en),
    .i_cfg_valid(vld),
    .i_cfg_ratio(rat),
    .o_cfg_ready(rdy),
    .i_div_clk(dclk),
    .o_div_en(div_en),
    .o_div_ratio(div_ratio),
    .o_bypass(byp),
    .o_busy(busy),
    .o_timeout(tout),
    .i_timeout_clr(tclr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] rat;
    logic       dclk;
    logic       en_x;
    logic [7:0] rat_x;
    logic       byp_x;
    logic       rdy_x;
    logic       busy_x;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e,
                         input logic [7:0] r, input logic b,
                         input logic y, input logic u,
                         input logic t);
    chk({tag, ".div_en"}, 32'(div_en), 32'(e));
    chk({tag, ".ratio"}, 32'(div_ratio), 32'(r));
    chk({tag, ".bypass"}, 32'(byp), 32'(b));
    chk({tag, ".ready"}, 32'(rdy), 32'(y));
    chk({tag, ".busy"}, 32'(busy), 32'(u));
    chk({tag, ".timeout"}, 32'(tout), 32'(t));
  endtask

  task automatic step(input logic e, input logic v,
                      input logic [7:0] r, input logic d,
                      input logic c);
    en   = e;
    vld  = v;
    rat  = r;
    dclk = d;
    tclr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic v,
                     input logic [7:0] r, input logic d,
                     input logic ex, input logic [7:0] rx,
                     input logic bx, input logic yx,
                     input logic ux);
    vec_t t;
    t.en     = e;
    t.vld    = v;
    t.rat    = r;
    t.dclk   = d;
    t.en_x   = ex;
    t.rat_x  = rx;
    t.byp_x  = bx;
    t.rdy_x  = yx;
    t.busy_x = ux;
    tbl.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // restart with reset ratio
    add(1, 0, 0, 0,  0, 2, 0, 0, 1);
    add(1, 0, 0, 0,  0, 2, 0, 0, 1);
    add(1, 0, 0, 0,  1, 2, 0, 1, 0);
    // load 4
    add(1, 1, 4, 0,  1, 2, 0, 0, 1);
    add(1, 0, 0, 1,  1, 2, 0, 0, 1);
    add(1, 0, 0, 0,  0, 2, 0, 0, 1);
    add(1, 0, 0, 0,  0, 4, 0, 0, 1);
    add(1, 0, 0, 0,  0, 4, 0, 0, 1);
    add(1, 0, 0, 0,  1, 4, 0, 1, 0);
    // load 8, valid during drain ignored
    add(1, 1, 8, 0,  1, 4, 0, 0, 1);
    add(1, 1, 3, 0,  1, 4, 0, 0, 1);
    add(1, 0, 0, 1,  1, 4, 0, 0, 1);
    add(1, 0, 0, 1,  1, 4, 0, 0, 1);
    add(1, 0, 0, 0,  0, 4, 0, 0, 1);
    add(1, 0, 0, 0,  0, 8, 0, 0, 1);
    add(1, 0, 0, 0,  0, 8, 0, 0, 1);
    add(1, 0, 0, 0,  1, 8, 0, 1, 0);
    // ratio 1 -> bypass
    add(1, 1, 1, 0,  1, 8, 0, 0, 1);
    add(1, 0, 0, 1,  1, 8, 0, 0, 1);
    add(1, 0, 0, 0,  0, 8, 0, 0, 1);
    add(1, 0, 0, 0,  0, 1, 1, 0, 1);
    add(1, 0, 0, 0,  0, 1, 1, 0, 1);
    add(1, 0, 0, 0,  0, 1, 1, 1, 0);
    add(1, 0, 0, 0,  0, 1, 1, 1, 0);
    // ratio 6 from bypass: one-cycle drain
    add(1, 1, 6, 0,  0, 1, 1, 0, 1);
    add(1, 0, 0, 0,  0, 1, 1, 0, 1);
    add(1, 0, 0, 0,  0, 6, 0, 0, 1);
    add(1, 0, 0, 0,  0, 6, 0, 0, 1);
    add(1, 0, 0, 0,  1, 6, 0, 1, 0);

    rst  = 1'b1;
    en   = 1'b0;
    vld  = 1'b0;
    rat  = 8'd0;
    dclk = 1'b0;
    tclr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 2, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rel.ready", 32'(rdy), 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].vld, tbl[i].rat, tbl[i].dclk, 1'b0);
      chk_all($sformatf("v%0d", i), tbl[i].en_x, tbl[i].rat_x,
              tbl[i].byp_x, tbl[i].rdy_x, tbl[i].busy_x, 1'b0);
    end

    // drain timeout with divider clock stuck low
    step(1, 1, 5, 0, 0);
    chk_all("to.enter", 1, 6, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0, 0, 0);
      chk($sformatf("to.drain%0d", i), 32'({div_en, busy, tout}),
          32'(3'b110));
    end
    step(1, 0, 0, 0, 0);
    chk_all("to.load", 0, 6, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    chk_all("to.settle", 0, 5, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_all("to.run", 1, 5, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    chk_all("to.clr", 1, 5, 0, 1, 0, 0);

    // enable drop and transfer together
    step(0, 1, 9, 0, 0);
    chk_all("ov.drain", 1, 5, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk_all("ov.hi", 1, 5, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk_all("ov.load", 0, 5, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk_all("ov.settle", 0, 9, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_all("ov.off", 0, 9, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_all("ov.stay", 0, 9, 0, 1, 0, 0);

    // reset pulse during settle
    step(1, 0, 0, 0, 0);
    chk_all("rs.settle", 0, 9, 0, 0, 1, 0);
    rst = 1'b1;
    #1;
    chk_all("rs.async", 0, 2, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_all("rs.rel", 0, 2, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_all("rs.run", 1, 2, 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Configuration and sequencing controller for the integer clock divider. It accepts divide-ratio updates through a valid/ready handshake and holds them in a shadow register. It stops the divider at a safe point (falling edge of the divided clock), loads the new ratio, and re-enables the divider after a settle window. Ratios below 2 are routed to bypass instead of the divider.

Parameters:
RATIO_WIDTH, 8, width of ratio bus (matches divider ratio_width)
RESET_RATIO, 2, o_div_ratio value after reset
SETTLE_CYC, 2, cycles divider is held disabled after a load (>=1)
TIMEOUT_CYC, 1024, max DRAIN cycles before a forced load (>=2)

Ports:
i_clk  in  1  system clock, also divider source clock
i_rst  in  1  asynchronous reset, active-high
i_enable  in  1  level; request divider running
i_cfg_valid  in  1  new ratio offered
i_cfg_ratio  in  RATIO_WIDTH  requested ratio
o_cfg_ready  out  1  ratio can be accepted this cycle
i_div_clk  in  1  divider output, registered in i_clk domain, fed back
o_div_en  out  1  divider clock enable
o_div_ratio  out  RATIO_WIDTH  ratio driven to divider
o_bypass  out  1  active ratio <2; downstream muxes i_clk through
o_busy  out  1  high in DRAIN, LOAD, SETTLE
o_timeout  out  1  sticky; a drain timed out
i_timeout_clr  in  1  clears o_timeout

Behaviour:
- Reset values (async, immediate): state OFF, o_div_en=0, o_div_ratio=RESET_RATIO, shadow=RESET_RATIO, o_bypass=(RESET_RATIO<2), o_busy=0, o_timeout=0, o_cfg_ready=0 while i_rst high. Reset mid-operation aborts any sequence with no pending-ratio memory.
- o_cfg_ready = 1 exactly when state is OFF or RUN (and not in reset). Transfer happens when i_cfg_valid & o_cfg_ready at a rising edge. Ratio is captured into shadow that edge.
- Edge detect: register i_div_clk into prev. fall = prev & ~i_div_clk. prev resets to 0.
- FSM, all outputs registered:
  - OFF: o_div_en=0. Transfer -> LOAD. Else i_enable=1 -> SETTLE (restart with current ratio).
  - RUN: o_div_en = ~o_bypass. Transfer -> DRAIN. Else i_enable=0 -> DRAIN.
  - DRAIN: o_div_en unchanged. Exit when any of: fall, o_bypass=1 (immediate, 1 cycle), or drain counter = TIMEOUT_CYC-1 (sets o_timeout). On exit, the pending transfer goes to LOAD; a disable-only exit goes to OFF with o_div_en=0.
  - LOAD: o_div_en=0. o_div_ratio<=shadow and o_bypass<=(shadow<2) on exit. Always -> SETTLE.
  - SETTLE: o_div_en=0. Counts SETTLE_CYC cycles. Then -> RUN if i_enable=1, else OFF.
- Pending flag marks DRAIN entered by a transfer, so the enable-drop and transfer cases are distinguished. If both happen in the same cycle, the transfer wins: DRAIN -> LOAD -> SETTLE -> OFF, new ratio kept.
- i_enable changes during DRAIN/LOAD/SETTLE are sampled only at the SETTLE exit.
- o_timeout: set on timeout exit, cleared by i_timeout_clr; set wins over simultaneous clr.
- Ratio is unsigned, full RATIO_WIDTH. Values 0 and 1 mean bypass. No other range check.
- Drain and settle counters clear on state entry. Counter width is sized to TIMEOUT_CYC/SETTLE_CYC with no wrap.

Test Plan:
- Reset release, i_enable=1, no cfg -> SETTLE 2 cycles, then o_div_en=1, o_div_ratio=2, o_cfg_ready=1 from first post-reset cycle.
- RUN with ratio 4, offer ratio 8 -> ready drops the next cycle; o_div_en falls only after the next i_div_clk 1->0; o_div_ratio=8 on LOAD exit; o_div_en=1 after 2 SETTLE cycles.
- RUN, offer ratio 1 -> after drain, o_bypass=1 and o_div_en stays 0 in RUN. Then offer ratio 6 -> DRAIN lasts 1 cycle, o_bypass=0, divider re-enabled.
- i_div_clk held at 0 in DRAIN (TIMEOUT_CYC=16) -> forced LOAD after 16 cycles, o_timeout=1 until i_timeout_clr.
- i_enable drop and cfg transfer in the same cycle -> ratio loaded, final state OFF, o_div_en=0.
- i_rst pulse during SETTLE -> all outputs at reset values within the reset cycle, o_div_ratio=RESET_RATIO.
